sram_ctrl: RTL and testbench

- Initiator-side controller that drives an array of ROWS N-bit SRAM words.
- Each word has row_select, write_enable, data_in and data_out pins.
- Converts a valid/ready request (read or write at an address) into a timed setup/strobe/hold sequence on the array pins.
- Returns a registered read response.
- Sits between the host/bus logic and the SRAM storage array.

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_row_decoder.sv | 21 ++
 rtl/sram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM array controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_READ  = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  localparam int unsigned WR_CYCLES_DEF = 2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/sram_row_decoder.sv
// Address to one-hot row decode with an out-of-range flag; purely combinational.
module sram_row_decoder
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW   = 4,
  parameter int unsigned ROWS = 16
) (
  input  logic [AW-1:0]   addr,
  output logic [ROWS-1:0] onehot_c,
  output logic            in_range_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (addr == AW'(i)) onehot_c[i] = 1'b1;
    end
    in_range_c = (32'(addr) < ROWS);
  end

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready request to timed setup/strobe/hold sequence on an SRAM word array,
// with a registered read response.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned ROWS      = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [N-1:0]    req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_rdata,
  output logic            rsp_err,
  output logic [ROWS-1:0] row_select,
  output logic            write_enable,
  output logic [N-1:0]    data_in,
  input  logic [N-1:0]    array_rdata
);

  localparam int unsigned CW = $clog2(WR_CYCLES + 1);

  state_e          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [N-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [ROWS-1:0] row_select_q, row_select_d;
  logic            write_enable_q, write_enable_d;
  logic [N-1:0]    data_in_q, data_in_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [ROWS-1:0] onehot_c;
  logic            in_range_c;

  sram_row_decoder #(
    .AW  (AW),
    .ROWS(ROWS)
  ) u_row_decoder (
    .addr      (req_addr),
    .onehot_c  (onehot_c),
    .in_range_c(in_range_c)
  );

  // Next state and next registered outputs; everything holds unless changed.
  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_err_d      = rsp_err_q;
    rsp_rdata_d    = rsp_rdata_q;
    row_select_d   = row_select_q;
    write_enable_d = write_enable_q;
    data_in_d      = data_in_q;
    write_d        = write_q;
    err_d          = err_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          write_d     = req_write;
          rsp_rdata_d = '0;
          if (in_range_c) begin
            state_d      = ST_SETUP;
            err_d        = 1'b0;
            row_select_d = onehot_c;
            data_in_d    = (req_write == OP_WRITE) ? req_wdata : '0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (write_q == OP_WRITE) begin
          state_d        = ST_WRITE;
          write_enable_d = 1'b1;
          cnt_d          = CW'(1);
        end else begin
          state_d = ST_READ;
        end
      end

      ST_WRITE: begin
        if (cnt_q == CW'(WR_CYCLES)) begin
          state_d        = ST_HOLD;
          write_enable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_HOLD: begin
        state_d      = ST_RESP;
        row_select_d = '0;
        data_in_d    = '0;
        rsp_valid_d  = 1'b1;
      end

      ST_READ: begin
        state_d      = ST_RESP;
        row_select_d = '0;
        rsp_rdata_d  = array_rdata;
        rsp_valid_d  = 1'b1;
      end

      // Error responses enter here with rsp_valid low and raise it one edge later.
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        req_ready_d    = 1'b1;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = 1'b0;
        row_select_d   = '0;
        write_enable_d = 1'b0;
        data_in_d      = '0;
      end
    endcase
  end

  // Async reset drops the array strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      row_select_q   <= '0;
      write_enable_q <= 1'b0;
      data_in_q      <= '0;
      write_q        <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
      row_select_q   <= row_select_d;
      write_enable_q <= write_enable_d;
      data_in_q      <= data_in_d;
      write_q        <= write_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign row_select   = row_select_q;
  assign write_enable = write_enable_q;
  assign data_in      = data_in_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM array emulation, transaction-level reference model
// with a per-cycle compare process, plus directed literal checks.
module tb_sram_ctrl;

  localparam int unsigned N    = 8;
  localparam int unsigned ROWS = 16;
  localparam int unsigned AW   = 4;
  localparam int          WRC  = 2;

  logic            clk;
  logic            rst_n;
  logic            req_valid, req_ready, req_write;
  logic [AW-1:0]   req_addr;
  logic [N-1:0]    req_wdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [N-1:0]    rsp_rdata;
  logic [ROWS-1:0] row_select;
  logic            write_enable;
  logic [N-1:0]    data_in, array_rdata;

  // Second instance with a non power-of-two row count
  logic            b_req_valid, b_req_ready, b_req_write;
  logic [AW-1:0]   b_req_addr;
  logic [N-1:0]    b_req_wdata;
  logic            b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [N-1:0]    b_rsp_rdata;
  logic [11:0]     b_row_select;
  logic            b_write_enable;
  logic [N-1:0]    b_data_in, b_array_rdata;

  int n_chk;
  int n_fail;

  sram_ctrl #(.N(N), .ROWS(ROWS), .AW(AW), .WR_CYCLES(WRC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .row_select(row_select), .write_enable(write_enable), .data_in(data_in),
    .array_rdata(array_rdata)
  );

  sram_ctrl #(.N(N), .ROWS(12), .AW(AW), .WR_CYCLES(WRC)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .row_select(b_row_select), .write_enable(b_write_enable), .data_in(b_data_in),
    .array_rdata(b_array_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // SRAM array emulation
  logic [N-1:0] mem [ROWS];
  always_comb begin
    array_rdata = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      if (row_select[i]) array_rdata = mem[i];
    end
  end
  initial begin
    for (int i = 0; i < int'(ROWS); i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < int'(ROWS); i++) begin
        if (write_enable && row_select[i]) mem[i] <= data_in;
      end
    end
  end

  // Reference model: one outstanding transaction, timeline measured in edges since accept
  logic [N-1:0] exp_mem [ROWS];
  bit           known   [ROWS];
  bit           m_busy, m_w, m_err, m_rdk;
  logic [AW-1:0] m_a;
  logic [N-1:0] m_d, m_rd;
  int           m_j, m_lat;

  initial begin
    m_busy = 0; m_j = 0; m_lat = 0; m_w = 0; m_err = 0; m_rdk = 1;
    m_a = '0; m_d = '0; m_rd = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      exp_mem[i] = '0;
      known[i]   = 1'b1;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        if (m_busy && m_w && !m_err) known[m_a] = 1'b0;
        m_busy = 0;
        m_j    = 0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_j = 0;
          m_w = req_write; m_a = req_addr; m_d = req_wdata;
          m_err = (32'(req_addr) >= ROWS);
          m_rd = '0; m_rdk = 1'b1;
          if (!m_err && m_w) begin
            exp_mem[m_a] = m_d;
            known[m_a]   = 1'b1;
          end else if (!m_err) begin
            m_rd  = exp_mem[m_a];
            m_rdk = known[m_a];
          end
          m_lat = m_err ? 1 : (m_w ? 2 + WRC : 2);
        end
      end else if (m_j >= m_lat && rsp_ready) begin
        m_busy = 0;
      end else begin
        m_j++;
      end
    end
  end

  // Per-cycle compare against the model plus array-pin invariants
  logic [N-1:0] rsp_q [$];
  initial begin
    logic [ROWS-1:0] prev_rs, e_rs;
    logic [N-1:0]    e_di;
    logic            prev_we, prev_rst, rv, ok, e_we;
    prev_rs = '0; prev_we = 1'b0; prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      rv   = m_busy && (m_j >= m_lat);
      ok   = m_busy && !m_err;
      e_rs = (ok && m_j <= (m_w ? WRC + 1 : 1)) ? (ROWS'(1) << m_a) : '0;
      e_we = ok && m_w && (m_j >= 1) && (m_j <= WRC);
      e_di = (ok && m_w && m_j <= WRC + 1) ? m_d : '0;
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(rv));
      chk("rsp_err", 32'(rsp_err), 32'(rv && m_err));
      if (rv && m_rdk) chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
      chk("row_select", 32'(row_select), 32'(e_rs));
      chk("write_enable", 32'(write_enable), 32'(e_we));
      chk("data_in", 32'(data_in), 32'(e_di));
      chk("rs_onehot0", 32'(row_select & (row_select - ROWS'(1))), 32'(0));
      if (write_enable) chk("we_without_row", 32'(row_select != '0), 32'(1));
      if (rst_n && prev_rst && row_select != prev_rs)
        chk("rs_change_under_we", 32'({prev_we, write_enable}), 32'(0));
      if (rst_n && rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
      prev_rs = row_select; prev_we = write_enable; prev_rst = rst_n;
    end
  end

  // Response-side handshake driver
  bit rr_rand, rr_val;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end
  end

  task automatic wait_accept();
    bit rdy, got;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) got = 1;
    end
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = N'($urandom);
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: request not accepted within 300 cycles");
    end
  endtask

  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [N-1:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    wait_accept();
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!m_busy) done = 1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: transaction did not complete within 300 cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rr_rand = 0; rr_val = 1;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1; b_array_rdata = 8'h5A;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("rst_row_select", 32'(row_select), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-write drops the strobes without a clock edge
    send_req(1'b1, 4'd3, 8'h3C);
    @(posedge clk);
    #2;
    chk("midwr_we_high", 32'(write_enable), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(write_enable), 32'(0));
    chk("async_rst_rs", 32'(row_select), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'(1));
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;

    // Directed write: addr 5, 0xA5, rsp_ready high in advance
    send_req(1'b1, 4'd5, 8'hA5);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      chk("wr_row_select", 32'(row_select), (j <= 3) ? 32'h0020 : 32'h0);
      chk("wr_we", 32'(write_enable), (j == 1 || j == 2) ? 32'd1 : 32'd0);
      chk("wr_data_in", 32'(data_in), (j <= 3) ? 32'hA5 : 32'h0);
      chk("wr_rsp_valid", 32'(rsp_valid), (j == 4) ? 32'd1 : 32'd0);
      if (j == 4) chk("wr_rsp_err", 32'(rsp_err), 32'(0));
    end
    @(posedge clk); #1;

    // Directed read: addr 5 returns 0xA5 two edges after accept
    send_req(1'b0, 4'd5, 8'h00);
    for (int j = 0; j <= 2; j++) begin
      @(negedge clk);
      chk("rd_we", 32'(write_enable), 32'(0));
      chk("rd_rsp_valid", 32'(rsp_valid), (j == 2) ? 32'd1 : 32'd0);
      if (j == 2) chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    end
    wait_idle();
    @(posedge clk); #1;

    // Backpressure with a request queued behind the response
    rr_val = 0;
    @(posedge clk); #1;
    send_req(1'b0, 4'd5, 8'h00);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_wdata = 8'h77;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_rsp_rdata", 32'(rsp_rdata), 32'hA5);
      chk("bp_req_ready", 32'(req_ready), 32'(0));
    end
    rr_val = 1;
    wait_accept();
    wait_idle();
    chk("bp_queued_write", 32'(exp_mem[7]), 32'h77);
    @(posedge clk); #1;

    // Back-to-back with random gaps
    rr_rand = 1;
    rsp_q.delete();
    send_req(1'b1, 4'd0, 8'h11);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    send_req(1'b1, 4'd15, 8'hFF);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    send_req(1'b0, 4'd0, 8'h00);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    send_req(1'b0, 4'd15, 8'h00);
    wait_idle();
    chk("b2b_count", 32'(rsp_q.size()), 32'(4));
    if (rsp_q.size() == 4) begin
      chk("b2b_rd0", 32'(rsp_q[2]), 32'h11);
      chk("b2b_rd15", 32'(rsp_q[3]), 32'hFF);
    end
    @(posedge clk); #1;

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_req(1'($urandom), AW'($urandom_range(0, ROWS - 1)), N'($urandom));
    end
    wait_idle();

    // Twelve-row instance: last valid row and the first two out-of-range addresses
    for (int a = 11; a <= 13; a++) begin
      b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = AW'(a); b_req_wdata = 8'hC3;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      for (int j = 0; j <= 3; j++) begin
        @(negedge clk);
        chk("r12_row_select", 32'(b_row_select),
            (a < 12 && j <= 1) ? 32'(12'(1) << a) : 32'h0);
        chk("r12_we", 32'(b_write_enable), 32'(0));
        chk("r12_data_in", 32'(b_data_in), 32'(0));
        chk("r12_rsp_valid", 32'(b_rsp_valid),
            ((a >= 12 && j == 1) || (a < 12 && j == 2)) ? 32'd1 : 32'd0);
        chk("r12_rsp_err", 32'(b_rsp_err), (a >= 12 && j == 1) ? 32'd1 : 32'd0);
        if (a >= 12 && j == 1) chk("r12_err_rdata", 32'(b_rsp_rdata), 32'h0);
        if (a < 12 && j == 2) chk("r12_rdata", 32'(b_rsp_rdata), 32'h5A);
        if (j == 0) chk("r12_req_ready", 32'(b_req_ready), 32'(0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
